fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter DEPTH, default 2: fetch-buffer entries; legal values 2 and 4.
REQ-003 clk_i  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n_i  input  1: reset; asynchronous, active-low.
REQ-005 stall_i  input  1: downstream IF/ID hold; no buffer pop while high.
REQ-006 flush_i  input  1: redirect; discard buffer and in-flight fetch.
REQ-007 target_i  input  32: redirect PC, sampled when flush_i=1.
REQ-008 imem_req_o  output  1: fetch request to instruction memory.
REQ-009 imem_addr_o  output  32: fetch address, equal to the current PC.
REQ-010 imem_gnt_i  input  1: request accepted in this cycle.
REQ-011 imem_rvalid_i  input  1: read data valid; arrives at least 1 cycle after grant.
REQ-012 imem_rdata_i  input  32: instruction word.
REQ-013 valid_o  output  1: buffer head valid.
REQ-014 pc_o  output  32: PC of the buffer head.
REQ-015 Instruction_o  output  32: instruction of the buffer head; 0 (bubble) when valid_o=0.

Function
REQ-016 The block SHALL have at most one outstanding memory request.
REQ-017 FSM states SHALL be IDLE (none outstanding), WAIT (response owed, kept) and DROP (response owed, discarded).
REQ-018 imem_req_o SHALL equal (state==IDLE) && (count + pending < DEPTH) && !flush_i, where pending = 0 in IDLE, so no response can ever arrive to a full buffer.
REQ-019 On imem_req_o && imem_gnt_i: state IDLE->WAIT, the issued PC is latched as req_pc, and PC <= PC + 4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-020 In WAIT, imem_rvalid_i SHALL push {req_pc, imem_rdata_i} into the buffer, then WAIT->IDLE; the next request may issue in the following cycle.
REQ-021 In DROP, imem_rvalid_i SHALL discard the data, then DROP->IDLE.
REQ-022 Pop SHALL occur when valid_o && !stall_i && !flush_i; simultaneous push and pop SHALL keep count unchanged.
REQ-023 Buffer SHALL be FIFO-ordered; head visible combinationally, so push-to-valid_o latency is 1 cycle.
REQ-024 flush_i SHALL take priority over every other event: buffer emptied (count=0), PC <= target_i, WAIT->DROP, a grant in the same cycle cannot occur (req forced low), and rvalid in the same cycle is discarded (WAIT/DROP->IDLE).
REQ-025 After flush in IDLE, the first request to target_i SHALL issue the next cycle.
REQ-026 stall_i SHALL NOT block fetching; fetching continues until the buffer fills.
REQ-027 imem_rvalid_i while IDLE SHALL be ignored.

Reset
REQ-028 Asserting rst_n_i low SHALL immediately set PC=RESET_PC, count=0, state=IDLE, valid_o=0, pc_o=0, Instruction_o=0, imem_req_o=0.
REQ-029 A response arriving after reset deassertion for a pre-reset request SHALL be ignored (state IDLE).
REQ-030 First request SHALL issue in the first cycle after rst_n_i rises, at RESET_PC.

Structure
REQ-031 Shared package SHALL hold FSM state encoding, NOP word (32'h0) and instruction-step constant (4).
REQ-032 The buffer SHALL be one sub-module, fetch_fifo (parameterised DEPTH, 64-bit entries, push/pop/count/flush).

Verification
REQ-033 Reset with RESET_PC=32'h100, 1-cycle gnt, 1-cycle rvalid latency -> addresses 100,104,108 issued; valid_o rises with pc_o=100.
REQ-034 stall_i held high for 10 cycles -> exactly DEPTH entries buffered, imem_req_o low, head unchanged; on release, entries popped in order 100,104.
REQ-035 flush_i with target_i=32'h200 while WAIT for 108 -> response for 108 dropped, valid_o=0 next cycle, next request address 200.
REQ-036 flush_i coincident with imem_rvalid_i -> data not buffered, count=0, next address = target_i.
REQ-037 PC=32'hFFFF_FFFC, grant -> next address 32'h0000_0000.
REQ-038 rst_n_i low mid-WAIT, late rvalid after release -> ignored, first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Covers FSM encoding, buffer entry layout and fetch step.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fstate_e;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] INSN_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus.
// The fetch unit is the master; memory is the slave.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: FIFO of {pc, insn} entries.
// Head is read combinationally; flush empties it.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !flush_i
                && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && !flush_i
                && (cnt_q != '0);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push)
                    - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= data_i;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request,
// responses buffered in order for the decode stage.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] target_i,
  fetch_unit_if.master imem,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] Instruction_o
);

  localparam int CW = $clog2(DEPTH + 1);

  fstate_e       state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] cnt;
  logic          buf_valid;
  fetch_entry_t  head;
  fetch_entry_t  push_e;
  logic          req;
  logic          fire;
  logic          push;
  logic          pop;

  // Gated by reset so no request escapes while held in reset.
  assign req = rst_n_i
            && (state_q == S_IDLE)
            && (cnt < CW'(DEPTH))
            && !flush_i;

  assign fire = req && imem.imem_gnt;
  assign push = (state_q == S_WAIT)
             && imem.imem_rvalid && !flush_i;
  assign pop  = buf_valid && !stall_i
             && !flush_i;

  assign push_e.pc   = req_pc_q;
  assign push_e.insn = imem.imem_rdata;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (fire) state_d = S_WAIT;
      S_WAIT: begin
        if (imem.imem_rvalid)
          state_d = S_IDLE;
        else if (flush_i)
          state_d = S_DROP;
      end
      S_DROP: if (imem.imem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    unique case (1'b1)
      flush_i: pc_d = target_i;
      fire: begin
        pc_d     = pc_q + INSN_STEP;
        req_pc_d = pc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (push_e),
    .pop_i   (pop),
    .valid_o (buf_valid),
    .head_o  (head),
    .count_o (cnt)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  assign valid_o       = buf_valid;
  assign pc_o          = buf_valid ? head.pc : '0;
  assign Instruction_o = buf_valid ? head.insn
                                   : NOP_WORD;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios then
// random traffic against a queue-based reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] target;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] insn;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .stall_i       (stall),
    .flush_i       (flush),
    .target_i      (target),
    .imem          (bus),
    .valid_o       (valid),
    .pc_o          (pc),
    .Instruction_o (insn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mq [$];
  logic [31:0] md_pc;
  logic [31:0] md_rpc;
  bit          md_out;
  bit          md_keep;

  bit          m_owed;
  int          m_lat;
  int          lat_max;
  logic [31:0] m_addr;
  logic [31:0] issued [$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] nth(input int i);
    return (issued.size() > i) ? issued[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    md_pc   = RPC;
    md_rpc  = '0;
    md_out  = 1'b0;
    md_keep = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},   {31'd0, bus.imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_pc"},    pc, 32'd0);
    chk({tag, "_insn"},  insn, 32'd0);
  endtask

  // One clock: drive at negedge, check, model the posedge.
  task automatic step(input bit st, input bit fl,
                      input logic [31:0] tg, input bit g,
                      input int rvm);
    bit          rv;
    bit          fire;
    bit          dfire;
    bit          xreq;
    bit          xval;
    logic [31:0] rd;
    logic [31:0] daddr;
    logic [31:0] xhpc;
    logic [31:0] xhin;
    rv = 1'b0;
    rd = $urandom;
    if (rvm == 1 && m_owed && m_lat == 0) begin
      rv = 1'b1;
      rd = word_of(m_addr);
    end else if (rvm == 2 && !m_owed) begin
      rv = 1'b1;
    end
    stall           = st;
    flush           = fl;
    target          = tg;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    #1;
    xreq = !md_out && (mq.size() < DEPTH) && !fl;
    xval = (mq.size() != 0);
    xhpc = xval ? mq[0][63:32] : 32'd0;
    xhin = xval ? mq[0][31:0]  : 32'd0;
    chk("req", {31'd0, bus.imem_req}, {31'd0, xreq});
    if (xreq) chk("addr", bus.imem_addr, md_pc);
    chk("valid", {31'd0, valid}, {31'd0, xval});
    chk("pc", pc, xhpc);
    chk("insn", insn, xhin);
    dfire = bus.imem_req && g;
    daddr = bus.imem_addr;
    fire  = xreq && g;
    if (dfire) issued.push_back(daddr);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      md_pc = tg;
      if (md_out) begin
        if (rv) md_out = 1'b0;
        else    md_keep = 1'b0;
      end
    end else begin
      if (xval && !st) void'(mq.pop_front());
      if (md_out && rv) begin
        if (md_keep) mq.push_back({md_rpc, rd});
        md_out = 1'b0;
      end
      if (fire) begin
        md_out  = 1'b1;
        md_keep = 1'b1;
        md_rpc  = md_pc;
        md_pc   = md_pc + 32'd4;
      end
    end
    if (rv && m_owed) m_owed = 1'b0;
    else if (m_owed && m_lat > 0) m_lat--;
    if (dfire) begin
      m_owed = 1'b1;
      m_addr = daddr;
      m_lat  = $urandom_range(lat_max, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h0;
    rst_n           = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;
    target          = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    m_owed          = 1'b0;
    m_lat           = 0;
    m_addr          = '0;
    lat_max         = 0;
    model_reset();
    #1;
    chk_reset_outs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back fetch after reset, 1-cycle latency.
    issued.delete();
    repeat (6) step(0, 0, '0, 1, 1);
    chk("boot_a0", nth(0), 32'h100);
    chk("boot_a1", nth(1), 32'h104);
    chk("boot_a2", nth(2), 32'h108);

    // Stall fills the buffer, then drains in order.
    repeat (10) step(1, 0, '0, 1, 1);
    chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
    chk("stall_valid", {31'd0, valid}, 32'd1);
    h0 = pc;
    step(1, 0, '0, 1, 1);
    chk("stall_head", pc, h0);
    step(0, 0, '0, 0, 1);
    chk("drain_next", pc, h0 + 32'd4);
    step(0, 0, '0, 0, 1);

    // Flush while a response is owed: it is dropped.
    step(0, 0, '0, 1, 0);
    issued.delete();
    step(0, 1, 32'h200, 1, 0);
    chk("flush_valid", {31'd0, valid}, 32'd0);
    repeat (4) step(0, 0, '0, 1, 1);
    chk("flush_addr", nth(0), 32'h200);

    // Flush in the same cycle as the response.
    issued.delete();
    step(0, 1, 32'h300, 0, 1);
    chk("frv_valid", {31'd0, valid}, 32'd0);
    step(0, 0, '0, 1, 0);
    chk("frv_addr", nth(0), 32'h300);
    step(0, 0, '0, 0, 1);

    // PC wraps past the top of the address space.
    issued.delete();
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, '0, 1, 0);
    repeat (3) step(0, 0, '0, 1, 1);
    chk("wrap_a0", nth(0), 32'hFFFF_FFFC);
    chk("wrap_a1", nth(1), 32'h0000_0000);

    // Unsolicited rvalid while idle is ignored.
    step(1, 0, '0, 0, 2);
    step(1, 0, '0, 0, 2);
    chk("spur_pc", pc, 32'h0000_0000);

    // Reset while a response is owed; late rvalid ignored.
    lat_max = 2;
    step(0, 0, '0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issued.delete();
    for (int i = 0; i < 6 && m_owed; i++) step(0, 0, '0, 0, 1);
    chk("late_rv_timeout", {31'd0, m_owed}, 32'd0);
    step(0, 0, '0, 1, 1);
    chk("rst_first", nth(0), RPC);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit          rs;
      bit          rf;
      bit          rg;
      int          rm;
      logic [31:0] rt;
      rs = ($urandom_range(2, 0) == 0);
      rf = ($urandom_range(11, 0) == 0);
      rg = ($urandom_range(3, 0) != 0);
      rm = ($urandom_range(7, 0) == 0) ? 2 :
           (($urandom_range(2, 0) != 0) ? 1 : 0);
      rt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8
                                       : ($urandom & 32'hFFFF_FFFC);
      step(rs, rf, rt, rg, rm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
